hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage ARMv8 pipeline; the producer side of the pipeline control that the forwarding path consumes.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Flushes wrong-path instructions when a branch resolves taken in MEM.
- Freezes the whole pipeline while the data memory is not ready, with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64: wait cycles in MEM_WAIT before mem_timeout_err is set.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRd  in  5  destination of the instruction in EX.
- IF_ID_RegisterRn1  in  5  source 1 of the instruction in ID.
- IF_ID_RegisterRm2  in  5  source 2 of the instruction in ID.
- IF_ID_UsesRm2  in  1  instruction in ID reads Rm2 (includes STUR data and CBZ operand).
- EX_MEM_PCSrc  in  1  branch in MEM resolved taken.
- dmem_req  in  1  MEM stage has an active data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  zero the control fields entering ID/EX.
- Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.
- EX_MEM_Flush  out  1  clear EX/MEM.
- mem_timeout_err  out  1  sticky watchdog flag.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, wait counter 0, mem_timeout_err=0.
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, Pipe_Freeze=0, all flushes 1.
  - On the first clk after release, outputs take their normal values.
- Control outputs are combinational from the inputs and the current state, so they act in the detecting cycle. State and counters are registered.
- load_use = ID_EX_MemRead && ID_EX_RegisterRd!=31 && (ID_EX_RegisterRd==IF_ID_RegisterRn1 || (IF_ID_UsesRm2 && ID_EX_RegisterRd==IF_ID_RegisterRm2)). XZR (31) never causes a hazard.
- mem_stall = dmem_req && !dmem_ready.
- Priority in every state: mem_stall > EX_MEM_PCSrc > load_use.
- RUN:
  - mem_stall: PCWrite=0, IF_ID_Write=0, Pipe_Freeze=1; next state MEM_WAIT, counter=1.
  - else PCSrc: IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush all 1; PCWrite=1 to load the target; next state FLUSH.
  - else load_use: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; stay in RUN. Exactly one bubble results, because ID/EX no longer holds the load in the next cycle.
  - else all enables 1, bubble and flushes 0.
- MEM_WAIT:
  - While !dmem_ready: freeze outputs held and counter increments, saturating at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, mem_timeout_err is set. It stays set until reset and does not release the freeze.
  - On dmem_ready: freeze released in that same cycle; counter cleared. If PCSrc is also high, flush as in RUN and go to FLUSH; otherwise go to RUN.
  - Load-use is evaluated only on the release cycle.
- FLUSH (one cycle):
  - PCSrc and load_use are masked, because the stages hold flushed bubbles.
  - mem_stall still goes to MEM_WAIT; otherwise go to RUN.
- Illegal state encoding: go to RUN.
- If rst_n asserts mid-wait, the counter clears and the watchdog flag clears.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output ports load_use_cnt, flush_cnt and mem_wait_cnt, each CNT_W wide.
  - load_use_cnt increments on each cycle with a bubble inserted.
  - flush_cnt increments on each entry to FLUSH.
  - mem_wait_cnt increments on each MEM_WAIT cycle.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline control package): state encodings RUN=2'b00, MEM_WAIT=2'b01, FLUSH=2'b10, and the constant XZR=5'd31.
  - The forwarding unit must use this same XZR constant.
- Sub-module: hazard_perf_counters, holding the three saturating counters. Instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- ID_EX_MemRead=1, ID_EX_RegisterRd=5, IF_ID_RegisterRn1=5 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly one cycle. Repeat with Rd=31 -> no stall.
- Load Rd=7, IF_ID_RegisterRm2=7: IF_ID_UsesRm2=0 -> no stall; IF_ID_UsesRm2=1 -> one bubble.
- EX_MEM_PCSrc=1 for one cycle -> all three flushes =1 that cycle, state_o=FLUSH the next cycle, then RUN.
- dmem_req=1 with dmem_ready low for 5 cycles -> Pipe_Freeze=1 for those 5 cycles. Release with dmem_ready=1 and PCSrc=1 in the same cycle -> freeze drops and flushes fire in that cycle.
- With MEM_TIMEOUT=4, dmem_ready held low -> mem_timeout_err rises once the counter reaches 4, freeze persists, and the flag stays high until rst_n is pulsed low.
- mem_stall, PCSrc and load_use all asserted together in RUN -> only freeze outputs are active and the next state is MEM_WAIT. Asserting rst_n mid-wait -> immediate return to the reset output values.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline-control definitions: FSM state encodings, the XZR register number
// (the forwarding unit uses this same constant), and the packed control-output word.
package hazard_detection_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } hduState_e;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic idExBubble;
        logic pipeFreeze;
        logic ifIdFlush;
        logic idExFlush;
        logic exMemFlush;
    } hduCtrl_t;

    localparam hduCtrl_t CTRL_NORMAL = '{pcWrite: 1'b1, ifIdWrite: 1'b1, default: 1'b0};
    localparam hduCtrl_t CTRL_BUBBLE = '{idExBubble: 1'b1, default: 1'b0};
    localparam hduCtrl_t CTRL_FREEZE = '{pipeFreeze: 1'b1, default: 1'b0};
    localparam hduCtrl_t CTRL_FLUSH  = '{pcWrite: 1'b1, ifIdFlush: 1'b1, idExFlush: 1'b1,
                                         exMemFlush: 1'b1, default: 1'b0};
    localparam hduCtrl_t CTRL_RESET  = '{idExBubble: 1'b1, ifIdFlush: 1'b1, idExFlush: 1'b1,
                                         exMemFlush: 1'b1, default: 1'b0};

    // A load into XZR never creates a dependency, so it can never stall ID.
    function automatic logic isLoadUse(
        input logic       memRead,
        input logic [4:0] rd,
        input logic [4:0] rn1,
        input logic [4:0] rm2,
        input logic       usesRm2
    );
        return memRead && (rd != XZR) && ((rd == rn1) || (usesRm2 && (rd == rm2)));
    endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side bundle of the hazard unit: register fields and stage status in,
// stall/flush/freeze controls out. master = pipeline datapath, slave = hazard unit.
interface hazard_detection_unit_if;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RegisterRd;
    logic [4:0] IF_ID_RegisterRn1;
    logic [4:0] IF_ID_RegisterRm2;
    logic       IF_ID_UsesRm2;
    logic       EX_MEM_PCSrc;
    logic       dmem_req;
    logic       dmem_ready;

    logic       PCWrite;
    logic       IF_ID_Write;
    logic       ID_EX_Bubble;
    logic       Pipe_Freeze;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       EX_MEM_Flush;

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
               IF_ID_UsesRm2, EX_MEM_PCSrc, dmem_req, dmem_ready,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
               IF_ID_UsesRm2, EX_MEM_PCSrc, dmem_req, dmem_ready,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush
    );
endinterface

// File: rtl/hazard_detection_unit_perf_counters.sv
// Three saturating event counters (bubbles, flush entries, memory-wait cycles)
// for the hazard unit; only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bubbleEvent,
    input  logic             flushEntry,
    input  logic             memWaitCycle,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    logic [2:0]       incEvent;
    logic [CNT_W-1:0] cntReg [3];

    assign incEvent = {memWaitCycle, flushEntry, bubbleEvent};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cntReg[gi] <= '0;
                end else if (incEvent[gi] && (cntReg[gi] != '1)) begin
                    cntReg[gi] <= cntReg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign load_use_cnt = cntReg[0];
    assign flush_cnt    = cntReg[1];
    assign mem_wait_cnt = cntReg[2];

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush/freeze controller for the 5-stage pipeline with a memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hazard_detection_unit_if.slave hduIf,
    output logic                   mem_timeout_err,
    output logic [1:0]             state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       load_use_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [CNT_W-1:0]       mem_wait_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    hduState_e         stateReg, stateNext;
    logic [WAIT_W-1:0] waitCntReg, waitCntNext;
    logic              errReg, errNext;
    logic              runReg;
    hduCtrl_t          ctrl;
    logic              loadUse, memStall, bubbleEvent;

    assign loadUse  = isLoadUse(hduIf.ID_EX_MemRead, hduIf.ID_EX_RegisterRd,
                                hduIf.IF_ID_RegisterRn1, hduIf.IF_ID_RegisterRm2,
                                hduIf.IF_ID_UsesRm2);
    assign memStall = hduIf.dmem_req && !hduIf.dmem_ready;

    always_comb begin
        ctrl        = CTRL_NORMAL;
        stateNext   = RUN;
        waitCntNext = '0;
        bubbleEvent = 1'b0;
        case (stateReg)
            RUN: begin
                if (memStall) begin
                    ctrl        = CTRL_FREEZE;
                    stateNext   = MEM_WAIT;
                    waitCntNext = WAIT_ONE;
                end else if (hduIf.EX_MEM_PCSrc) begin
                    ctrl      = CTRL_FLUSH;
                    stateNext = FLUSH;
                end else if (loadUse) begin
                    ctrl        = CTRL_BUBBLE;
                    bubbleEvent = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch and load-use decisions wait for the release cycle.
                if (!hduIf.dmem_ready) begin
                    ctrl        = CTRL_FREEZE;
                    stateNext   = MEM_WAIT;
                    waitCntNext = (waitCntReg >= WAIT_MAX) ? waitCntReg : waitCntReg + 1'b1;
                end else if (hduIf.EX_MEM_PCSrc) begin
                    ctrl      = CTRL_FLUSH;
                    stateNext = FLUSH;
                end else if (loadUse) begin
                    ctrl        = CTRL_BUBBLE;
                    bubbleEvent = 1'b1;
                end
            end
            FLUSH: begin
                // Stages hold flushed bubbles now, so PCSrc and load-use are stale.
                if (memStall) begin
                    ctrl        = CTRL_FREEZE;
                    stateNext   = MEM_WAIT;
                    waitCntNext = WAIT_ONE;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase

        // Outputs keep their reset values until the first clock after reset release.
        if (!runReg) begin
            ctrl        = CTRL_RESET;
            stateNext   = RUN;
            waitCntNext = '0;
            bubbleEvent = 1'b0;
        end
    end

    assign errNext = errReg || ((stateNext == MEM_WAIT) && (waitCntNext == WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runReg     <= 1'b0;
            stateReg   <= RUN;
            waitCntReg <= '0;
            errReg     <= 1'b0;
        end else begin
            runReg     <= 1'b1;
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
            errReg     <= errNext;
        end
    end

    assign hduIf.PCWrite      = ctrl.pcWrite;
    assign hduIf.IF_ID_Write  = ctrl.ifIdWrite;
    assign hduIf.ID_EX_Bubble = ctrl.idExBubble;
    assign hduIf.Pipe_Freeze  = ctrl.pipeFreeze;
    assign hduIf.IF_ID_Flush  = ctrl.ifIdFlush;
    assign hduIf.ID_EX_Flush  = ctrl.idExFlush;
    assign hduIf.EX_MEM_Flush = ctrl.exMemFlush;
    assign mem_timeout_err    = errReg;
    assign state_o            = stateReg;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .bubbleEvent  (bubbleEvent),
        .flushEntry   (runReg && (stateNext == FLUSH)),
        .memWaitCycle (runReg && (stateReg == MEM_WAIT)),
        .load_use_cnt (load_use_cnt),
        .flush_cnt    (flush_cnt),
        .mem_wait_cnt (mem_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Table-driven bench for hazard_detection_unit (MEM_TIMEOUT=4) with an expected-result
// queue, plus hand sequences for reset behaviour, mid-wait reset and the watchdog.
module tb_hazard_detection_unit;

    // {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    localparam logic [6:0] NRM = 7'b1100000;
    localparam logic [6:0] BUB = 7'b0010000;
    localparam logic [6:0] FRZ = 7'b0001000;
    localparam logic [6:0] FLS = 7'b1000111;
    localparam logic [6:0] RST = 7'b0010111;
    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_FLSH = 2'b10;

    typedef struct {
        logic       memRead;
        logic [4:0] rd;
        logic [4:0] rn1;
        logic [4:0] rm2;
        logic       usesRm2;
        logic       pcSrc;
        logic       req;
        logic       ready;
        logic [6:0] ctrl;
        logic       err;
        logic [1:0] state;
    } vec_t;

    typedef struct {
        logic [6:0] ctrl;
        logic       err;
        logic [1:0] state;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic memTimeoutErr;
    logic [1:0] stateO;
    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    exp_t sb[$];

    hazard_detection_unit_if hduBus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] loadUseCnt, flushCnt, memWaitCnt;
`endif

    always #5 clk = ~clk;

    hazard_detection_unit #(
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hduIf           (hduBus),
        .mem_timeout_err (memTimeoutErr),
        .state_o         (stateO)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .load_use_cnt    (loadUseCnt),
        .flush_cnt       (flushCnt),
        .mem_wait_cnt    (memWaitCnt)
`endif
    );

    function automatic vec_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic u, input logic pc,
                                input logic rq, input logic rdy, input logic [6:0] c,
                                input logic e, input logic [1:0] st);
        vec_t v;
        v.memRead = mr; v.rd = rd; v.rn1 = rn; v.rm2 = rm; v.usesRm2 = u;
        v.pcSrc = pc; v.req = rq; v.ready = rdy; v.ctrl = c; v.err = e; v.state = st;
        return v;
    endfunction

    function automatic logic [6:0] ctrlNow();
        return {hduBus.PCWrite, hduBus.IF_ID_Write, hduBus.ID_EX_Bubble, hduBus.Pipe_Freeze,
                hduBus.IF_ID_Flush, hduBus.ID_EX_Flush, hduBus.EX_MEM_Flush};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [6:0] c, input logic e,
                            input logic [1:0] st);
        check({tag, ".ctrl"},  {1'b0, ctrlNow()},      {1'b0, c});
        check({tag, ".err"},   {7'b0, memTimeoutErr},  {7'b0, e});
        check({tag, ".state"}, {6'b0, stateO},         {6'b0, st});
    endtask

    task automatic drive(input vec_t v);
        hduBus.ID_EX_MemRead     = v.memRead;
        hduBus.ID_EX_RegisterRd  = v.rd;
        hduBus.IF_ID_RegisterRn1 = v.rn1;
        hduBus.IF_ID_RegisterRm2 = v.rm2;
        hduBus.IF_ID_UsesRm2     = v.usesRm2;
        hduBus.EX_MEM_PCSrc      = v.pcSrc;
        hduBus.dmem_req          = v.req;
        hduBus.dmem_ready        = v.ready;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
    task automatic applyRow(input vec_t v, input string tag);
        exp_t e;
        drive(v);
        sb.push_back('{ctrl: v.ctrl, err: v.err, state: v.state});
        @(negedge clk);
        e = sb.pop_front();
        checkAll(tag, e.ctrl, e.err, e.state);
        $display("%s: in mr=%b rd=%0d rn=%0d rm=%0d u=%b pc=%b req=%b rdy=%b -> ctrl=%b err=%b st=%0d",
                 tag, v.memRead, v.rd, v.rn1, v.rm2, v.usesRm2, v.pcSrc, v.req, v.ready,
                 ctrlNow(), memTimeoutErr, stateO);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, S_RUN);
        drive(idle);

        // Load-use detection, XZR exemption, Rm2 gating
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        vecs.push_back(mk(1,  5,  5,  0, 0, 0, 0, 0, BUB, 0, S_RUN));
        vecs.push_back(mk(0,  5,  5,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        vecs.push_back(mk(1, 31, 31,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        vecs.push_back(mk(1, 31,  0, 31, 1, 0, 0, 0, NRM, 0, S_RUN));
        vecs.push_back(mk(1,  7,  0,  7, 0, 0, 0, 0, NRM, 0, S_RUN));
        vecs.push_back(mk(1,  7,  0,  7, 1, 0, 0, 0, BUB, 0, S_RUN));
        vecs.push_back(mk(0,  7,  0,  7, 1, 0, 0, 0, NRM, 0, S_RUN));
        vecs.push_back(mk(0,  3,  3,  3, 1, 0, 0, 0, NRM, 0, S_RUN));
        // Taken branch: flush, one FLUSH cycle, back to RUN
        vecs.push_back(mk(0,  0,  0,  0, 0, 1, 0, 0, FLS, 0, S_RUN));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 0, S_FLSH));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        // PCSrc beats load-use; both masked in FLUSH
        vecs.push_back(mk(1,  5,  5,  0, 0, 1, 0, 0, FLS, 0, S_RUN));
        vecs.push_back(mk(1,  5,  5,  0, 0, 1, 0, 0, NRM, 0, S_FLSH));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        // Memory stall in FLUSH still freezes
        vecs.push_back(mk(0,  0,  0,  0, 0, 1, 0, 0, FLS, 0, S_RUN));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 1, 0, FRZ, 0, S_FLSH));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 1, 1, NRM, 0, S_WAIT));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        // All three hazards together: freeze wins; release with PCSrc flushes
        vecs.push_back(mk(1,  5,  5,  0, 0, 1, 1, 0, FRZ, 0, S_RUN));
        vecs.push_back(mk(1,  5,  5,  0, 0, 1, 1, 1, FLS, 0, S_WAIT));
        vecs.push_back(mk(1,  5,  5,  0, 0, 0, 0, 0, NRM, 0, S_FLSH));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        // Release with only load-use pending inserts the bubble in the release cycle
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 1, 0, FRZ, 0, S_RUN));
        vecs.push_back(mk(1,  5,  5,  0, 0, 0, 1, 1, BUB, 0, S_WAIT));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 0, S_RUN));
        // Five-cycle freeze; PCSrc during the wait is ignored; watchdog trips at 4
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 1, 0, FRZ, 0, S_RUN));
        vecs.push_back(mk(0,  0,  0,  0, 0, 1, 1, 0, FRZ, 0, S_WAIT));
        vecs.push_back(mk(0,  0,  0,  0, 0, 1, 1, 0, FRZ, 0, S_WAIT));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 1, 0, FRZ, 0, S_WAIT));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 1, 0, FRZ, 1, S_WAIT));
        vecs.push_back(mk(0,  0,  0,  0, 0, 1, 1, 1, FLS, 1, S_WAIT));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 1, S_FLSH));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, NRM, 1, S_RUN));
        vecs.push_back(mk(0,  0,  0,  0, 0, 0, 1, 1, NRM, 1, S_RUN));

        // Reset values while rst_n is low and until the first clock after release
        #12;
        checkAll("reset_low", RST, 1'b0, S_RUN);
        rst_n = 1'b1;
        #1;
        checkAll("reset_released_preclk", RST, 1'b0, S_RUN);
        $display("reset: ctrl=%b err=%b st=%0d", ctrlNow(), memTimeoutErr, stateO);
        @(posedge clk);
        #1;

        foreach (vecs[i]) applyRow(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a memory wait
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, S_RUN),  "midwait0");
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, S_WAIT), "midwait1");
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("midwait_reset", RST, 1'b0, S_RUN);
        $display("midwait_reset: ctrl=%b err=%b st=%0d", ctrlNow(), memTimeoutErr, stateO);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counter restarts from zero: watchdog trips after four wait increments again
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, S_RUN),  "wd0");
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, S_WAIT), "wd1");
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, S_WAIT), "wd2");
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, S_WAIT), "wd3");
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, S_WAIT), "wd4");
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, S_WAIT), "wd5");
        applyRow(mk(0, 0, 0, 0, 0, 0, 1, 1, NRM, 1, S_WAIT), "wd_release");
        applyRow(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, S_RUN),  "wd_sticky0");
        applyRow(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, S_RUN),  "wd_sticky1");

        // Only a reset pulse clears the sticky flag
        rst_n = 1'b0;
        #1;
        checkAll("wd_reset", RST, 1'b0, S_RUN);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyRow(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, S_RUN), "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
